// File: rtl/acc_n_driver.sv
// -----------------------------------------------------------------------------
// acc_n_driver
//
// Upstream producer for a 4-column accumulator bank.
//
// Rows arrive over a valid/ready handshake. Each row is split into its column
// elements, and each element goes down its own skew chain. This places column
// k exactly k cycles behind column 0 on the accumulator inputs. The rows are
// framed into blocks of blockLen rows. The first row of every block carries a
// clear flag, so each accumulator restarts its sum for that block.
//
// After the last row of a block is accepted, the block stops taking new rows.
// It waits long enough for that row to reach the slowest column and to be
// summed there. It then captures all column sums and holds them on a
// valid/ready output until the consumer takes them.
//
// Accumulator contract (external):
//   z_k <= clear_k ? a_k : z_k + a_k   (registered, 1-cycle latency, wraps)
//
// Ports:
//   clk              clock, single domain
//   rst              synchronous active-high reset
//   in_valid         row available
//   in_ready         block can accept a row
//   in_data          row; column k at [k*aBits +: aBits]
//   a_0..a_3         element driven to accumulator column k
//   clear_0..clear_3 accumulator k loads a_k instead of adding
//   z_0..z_3         accumulator column outputs
//   out_valid        captured block sums valid
//   out_ready        consumer takes sums
//   out_data         sums; column k at [k*zBits +: zBits]
// -----------------------------------------------------------------------------
module acc_n_driver #(
    parameter int arraySize = 4,
    parameter int aBits     = 8,
    parameter int zBits     = 12,
    parameter int blockLen  = 4,
    parameter int cntBits   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [arraySize*aBits-1:0]   in_data,
    output logic [aBits-1:0]             a_0,
    output logic [aBits-1:0]             a_1,
    output logic [aBits-1:0]             a_2,
    output logic [aBits-1:0]             a_3,
    output logic                         clear_0,
    output logic                         clear_1,
    output logic                         clear_2,
    output logic                         clear_3,
    input  logic [zBits-1:0]             z_0,
    input  logic [zBits-1:0]             z_1,
    input  logic [zBits-1:0]             z_2,
    input  logic [zBits-1:0]             z_3,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [arraySize*zBits-1:0]   out_data
);

    // The drain phase counts 0 .. arraySize inclusive. That is arraySize+1
    // cycles, which is enough for the last row to reach column arraySize-1
    // and be summed there.
    localparam int                    DRN_BITS = $clog2(arraySize + 1);
    localparam logic [DRN_BITS-1:0]   DRN_LAST = DRN_BITS'(arraySize);
    localparam logic [cntBits-1:0]    ROW_LAST = cntBits'(blockLen - 1);
    localparam logic [cntBits-1:0]    ROW_ZERO = {cntBits{1'b0}};

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [cntBits-1:0]             r_row_cnt;
    logic [cntBits-1:0]             w_row_cnt_nxt;
    logic [DRN_BITS-1:0]            r_drain_cnt;
    logic [DRN_BITS-1:0]            w_drain_cnt_nxt;
    logic                           r_in_ready;
    logic                           w_in_ready_nxt;
    logic                           r_out_valid;
    logic                           w_out_valid_nxt;
    logic                           w_capture;
    logic                           w_accept;
    logic                           w_first_row;
    logic                           w_last_row;
    logic [arraySize*zBits-1:0]     r_out_data;
    logic [arraySize*zBits-1:0]     w_z_row;

    // Taps at the end of each column's skew chain.
    logic [aBits-1:0]               w_a_tap   [arraySize];
    logic                           w_clr_tap [arraySize];

    assign w_accept    = in_valid & r_in_ready;
    assign w_first_row = (r_row_cnt == ROW_ZERO);
    assign w_last_row  = (r_row_cnt == ROW_LAST);
    assign w_z_row     = {z_3, z_2, z_1, z_0};

    // Row framing counter: advance on every accepted row, wrap after the last row of a block
    always_comb begin
        w_row_cnt_nxt = r_row_cnt;
        if (w_accept) begin
            if (w_last_row) begin
                w_row_cnt_nxt = ROW_ZERO;
            end else begin
                w_row_cnt_nxt = r_row_cnt + cntBits'(1);
            end
        end else begin
            w_row_cnt_nxt = r_row_cnt;
        end
    end

    // Block FSM next-state and registered-output next values
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_out_valid_nxt = r_out_valid;
        w_capture       = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_accept && w_last_row) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = {DRN_BITS{1'b0}};
                end else begin
                    w_state_nxt     = S_FILL;
                end
            end
            S_DRAIN: begin
                // Only bubbles follow the last row, so every column sum is
                // final in the last drain cycle and can be sampled then.
                if (r_drain_cnt == DRN_LAST) begin
                    w_capture       = 1'b1;
                    w_state_nxt     = S_HOLD;
                    w_out_valid_nxt = 1'b1;
                    w_drain_cnt_nxt = {DRN_BITS{1'b0}};
                end else begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = r_drain_cnt + DRN_BITS'(1);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt     = S_FILL;
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt     = S_HOLD;
                    w_out_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = S_FILL;
                w_out_valid_nxt = 1'b0;
                w_drain_cnt_nxt = {DRN_BITS{1'b0}};
            end
        endcase
        // in_ready is registered from the next state, so it equals "state is FILL".
        if (w_state_nxt == S_FILL) begin
            w_in_ready_nxt = 1'b1;
        end else begin
            w_in_ready_nxt = 1'b0;
        end
    end

    // FSM state, framing/drain counters and handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_row_cnt   <= ROW_ZERO;
            r_drain_cnt <= {DRN_BITS{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_cnt   <= w_row_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Result register: samples all column sums once per block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= {(arraySize*zBits){1'b0}};
        end else if (w_capture) begin
            r_out_data <= w_z_row;
        end
    end

    // Per-column skew chains. Column k has k+1 stages. A row accepted in cycle
    // t therefore appears on a_k/clear_k in cycle t+1+k. Cycles without an
    // accept push a bubble (zero element, no clear), and zeros do not change
    // the sums.
    for (genvar k = 0; k < arraySize; k++) begin : g_col
        logic [aBits-1:0] r_a_sr   [k+1];
        logic             r_clr_sr [k+1];

        // Shift the element and first-row flag one stage per cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= k; s++) begin
                    r_a_sr[s]   <= {aBits{1'b0}};
                    r_clr_sr[s] <= 1'b0;
                end
            end else begin
                r_a_sr[0]   <= w_accept ? in_data[k*aBits +: aBits] : {aBits{1'b0}};
                r_clr_sr[0] <= w_accept & w_first_row;
                for (int s = 1; s <= k; s++) begin
                    r_a_sr[s]   <= r_a_sr[s-1];
                    r_clr_sr[s] <= r_clr_sr[s-1];
                end
            end
        end

        assign w_a_tap[k]   = r_a_sr[k];
        assign w_clr_tap[k] = r_clr_sr[k];
    end

    assign a_0       = w_a_tap[0];
    assign a_1       = w_a_tap[1];
    assign a_2       = w_a_tap[2];
    assign a_3       = w_a_tap[3];
    assign clear_0   = w_clr_tap[0];
    assign clear_1   = w_clr_tap[1];
    assign clear_2   = w_clr_tap[2];
    assign clear_3   = w_clr_tap[3];
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_acc_n_driver.sv
// -----------------------------------------------------------------------------
// tb_acc_n_driver
//
// Bench for acc_n_driver. Behavioural accumulators close the loop on z_k.
//
// A timeline model predicts every output on every cycle. It records each
// accepted row by cycle, derives a_k/clear_k from the row accepted 1+k cycles
// earlier, and sums each block with plain arithmetic. It expects out_valid
// six cycles after the last row of a block.
//
// Directed tests add literal expectations. Variant instances cover
// blockLen=16 (zBits 12 and 8) and blockLen=1.
// -----------------------------------------------------------------------------
module tb_acc_n_driver;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  a_0, a_1, a_2, a_3;
    logic        clear_0, clear_1, clear_2, clear_3;
    logic [11:0] z_0, z_1, z_2, z_3;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic [31:0] a_vec;
    logic [3:0]  clr_vec;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_clr [4] = '{0, 0, 0, 0};

    assign a_vec   = {a_3, a_2, a_1, a_0};
    assign clr_vec = {clear_3, clear_2, clear_1, clear_0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    acc_n_driver dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a_0(a_0), .a_1(a_1), .a_2(a_2), .a_3(a_3),
        .clear_0(clear_0), .clear_1(clear_1), .clear_2(clear_2), .clear_3(clear_3),
        .z_0(z_0), .z_1(z_1), .z_2(z_2), .z_3(z_3),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always @(posedge clk) begin
        z_0 <= clear_0 ? {4'd0, a_0} : z_0 + {4'd0, a_0};
        z_1 <= clear_1 ? {4'd0, a_1} : z_1 + {4'd0, a_1};
        z_2 <= clear_2 ? {4'd0, a_2} : z_2 + {4'd0, a_2};
        z_3 <= clear_3 ? {4'd0, a_3} : z_3 + {4'd0, a_3};
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (clr_vec[k]) n_clr[k] <= n_clr[k] + 1;
        end
    end

    // ---------------- variant instances ----------------
    logic        v_valid;
    logic [31:0] v_data;
    logic        v16_ready, v16_ovalid, v8_ready, v8_ovalid;
    logic [7:0]  v16_a0, v16_a1, v16_a2, v16_a3, v8_a0, v8_a1, v8_a2, v8_a3;
    logic        v16_c0, v16_c1, v16_c2, v16_c3, v8_c0, v8_c1, v8_c2, v8_c3;
    logic [11:0] v16_z0, v16_z1, v16_z2, v16_z3;
    logic [7:0]  v8_z0, v8_z1, v8_z2, v8_z3;
    logic [47:0] v16_odata;
    logic [31:0] v8_odata;

    acc_n_driver #(.blockLen(16), .cntBits(4), .zBits(12)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v_valid), .in_ready(v16_ready), .in_data(v_data),
        .a_0(v16_a0), .a_1(v16_a1), .a_2(v16_a2), .a_3(v16_a3),
        .clear_0(v16_c0), .clear_1(v16_c1), .clear_2(v16_c2), .clear_3(v16_c3),
        .z_0(v16_z0), .z_1(v16_z1), .z_2(v16_z2), .z_3(v16_z3),
        .out_valid(v16_ovalid), .out_ready(1'b1), .out_data(v16_odata)
    );

    acc_n_driver #(.blockLen(16), .cntBits(4), .zBits(8)) dut16n (
        .clk(clk), .rst(rst), .in_valid(v_valid), .in_ready(v8_ready), .in_data(v_data),
        .a_0(v8_a0), .a_1(v8_a1), .a_2(v8_a2), .a_3(v8_a3),
        .clear_0(v8_c0), .clear_1(v8_c1), .clear_2(v8_c2), .clear_3(v8_c3),
        .z_0(v8_z0), .z_1(v8_z1), .z_2(v8_z2), .z_3(v8_z3),
        .out_valid(v8_ovalid), .out_ready(1'b1), .out_data(v8_odata)
    );

    always @(posedge clk) begin
        v16_z0 <= v16_c0 ? {4'd0, v16_a0} : v16_z0 + {4'd0, v16_a0};
        v16_z1 <= v16_c1 ? {4'd0, v16_a1} : v16_z1 + {4'd0, v16_a1};
        v16_z2 <= v16_c2 ? {4'd0, v16_a2} : v16_z2 + {4'd0, v16_a2};
        v16_z3 <= v16_c3 ? {4'd0, v16_a3} : v16_z3 + {4'd0, v16_a3};
        v8_z0  <= v8_c0 ? v8_a0 : v8_z0 + v8_a0;
        v8_z1  <= v8_c1 ? v8_a1 : v8_z1 + v8_a1;
        v8_z2  <= v8_c2 ? v8_a2 : v8_z2 + v8_a2;
        v8_z3  <= v8_c3 ? v8_a3 : v8_z3 + v8_a3;
    end

    logic        w1_valid, d1_ready, d1_ovalid;
    logic [31:0] w1_data;
    logic [7:0]  d1_a0, d1_a1, d1_a2, d1_a3;
    logic        d1_c0, d1_c1, d1_c2, d1_c3;
    logic [11:0] d1_z0, d1_z1, d1_z2, d1_z3;
    logic [47:0] d1_odata;
    logic [31:0] d1_avec;
    logic [3:0]  d1_cvec;

    assign d1_avec = {d1_a3, d1_a2, d1_a1, d1_a0};
    assign d1_cvec = {d1_c3, d1_c2, d1_c1, d1_c0};

    acc_n_driver #(.blockLen(1), .cntBits(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(w1_valid), .in_ready(d1_ready), .in_data(w1_data),
        .a_0(d1_a0), .a_1(d1_a1), .a_2(d1_a2), .a_3(d1_a3),
        .clear_0(d1_c0), .clear_1(d1_c1), .clear_2(d1_c2), .clear_3(d1_c3),
        .z_0(d1_z0), .z_1(d1_z1), .z_2(d1_z2), .z_3(d1_z3),
        .out_valid(d1_ovalid), .out_ready(1'b1), .out_data(d1_odata)
    );

    always @(posedge clk) begin
        d1_z0 <= d1_c0 ? {4'd0, d1_a0} : d1_z0 + {4'd0, d1_a0};
        d1_z1 <= d1_c1 ? {4'd0, d1_a1} : d1_z1 + {4'd0, d1_a1};
        d1_z2 <= d1_c2 ? {4'd0, d1_a2} : d1_z2 + {4'd0, d1_a2};
        d1_z3 <= d1_c3 ? {4'd0, d1_a3} : d1_z3 + {4'd0, d1_a3};
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] row(input logic [7:0] c0, input logic [7:0] c1,
                                        input logic [7:0] c2, input logic [7:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic wait_out(input string nm, input int t_last, input logic [47:0] exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk({nm, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({nm, "_latency"}, 64'(cyc - t_last), 64'd6);
            chk({nm, "_data"}, 64'(out_data), 64'(exp));
        end
    endtask

    // ---------------- timeline model + per-cycle compare ----------------
    int          m_cyc, m_last_rst, m_done, m_rows, p, s;
    bit          m_init, m_busy, acc, ov, ec;
    int          m_sum [4];
    int          hc [64];
    bit          hv [64];
    bit          hf [64];
    logic [31:0] hd [64];
    logic [47:0] e48;
    logic [7:0]  ea;

    initial begin
        m_cyc = 0; m_init = 1'b0; m_busy = 1'b0; m_rows = 0; m_last_rst = -1; m_done = 0;
        for (int i = 0; i < 64; i++) begin
            hc[i] = -1; hv[i] = 1'b0; hf[i] = 1'b0; hd[i] = 32'd0;
        end
        for (int k = 0; k < 4; k++) m_sum[k] = 0;
        forever begin
            @(posedge clk);
            m_cyc = m_cyc + 1;
            p     = m_cyc - 1;   // inputs now visible belong to cycle p
            acc   = 1'b0;
            if (rst) begin
                m_init = 1'b1; m_busy = 1'b0; m_rows = 0; m_last_rst = p;
            end else if (m_init) begin
                if (!m_busy && in_valid) begin
                    acc = 1'b1;
                end else if (m_busy && p >= m_done + 6 && out_ready) begin
                    m_busy = 1'b0;
                end
                if (acc) begin
                    hf[p % 64] = (m_rows == 0);
                    for (int k = 0; k < 4; k++) begin
                        if (m_rows == 0) m_sum[k] = int'(in_data[8*k +: 8]);
                        else             m_sum[k] = (m_sum[k] + int'(in_data[8*k +: 8])) % 4096;
                    end
                    m_rows = m_rows + 1;
                    if (m_rows == 4) begin
                        m_rows = 0; m_busy = 1'b1; m_done = p;
                    end
                end
            end
            hc[p % 64] = p; hv[p % 64] = acc; hd[p % 64] = in_data;
            @(negedge clk);
            if (m_init) begin
                chk("in_ready", 64'(in_ready), 64'(!m_busy));
                ov = m_busy && (m_cyc >= m_done + 6);
                chk("out_valid", 64'(out_valid), 64'(ov));
                if (ov) begin
                    for (int k = 0; k < 4; k++) e48[12*k +: 12] = m_sum[k][11:0];
                    chk("out_data", 64'(out_data), 64'(e48));
                end
                for (int k = 0; k < 4; k++) begin
                    s  = m_cyc - 1 - k;
                    ea = 8'd0; ec = 1'b0;
                    if (s >= 0 && s > m_last_rst) begin
                        if (hc[s % 64] == s && hv[s % 64]) begin
                            ea = hd[s % 64][8*k +: 8];
                            ec = hf[s % 64];
                        end
                    end
                    chk($sformatf("a_%0d", k), 64'(a_vec[8*k +: 8]), 64'(ea));
                    chk($sformatf("clear_%0d", k), 64'(clr_vec[k]), 64'(ec));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int t;
    int base [4];
    bit seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
        v_valid = 1'b0; v_data = 32'd0; w1_valid = 1'b0; w1_data = 32'd0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_a", 64'(a_vec), 64'd0);
        chk("rst_clear", 64'(clr_vec), 64'd0);

        // T1: back-to-back block, consumer ready
        tick();
        for (int k = 0; k < 4; k++) base[k] = n_clr[k];
        send(row(8'd1, 8'd10, 8'd255, 8'd0));
        send(row(8'd2, 8'd20, 8'd255, 8'd0));
        send(row(8'd3, 8'd30, 8'd255, 8'd0));
        t = cyc;
        send(row(8'd4, 8'd40, 8'd255, 8'd0));
        in_valid = 1'b0;
        wait_out("t1", t, {12'd0, 12'h3FC, 12'd100, 12'd10});
        @(negedge clk);
        chk("t1_ready_after", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) chk($sformatf("t1_clr_cnt_%0d", k), 64'(n_clr[k] - base[k]), 64'd1);

        // T2: two bubbles inside the block
        tick();
        for (int k = 0; k < 4; k++) base[k] = n_clr[k];
        send(row(8'd1, 8'd10, 8'd255, 8'd0));
        send(row(8'd2, 8'd20, 8'd255, 8'd0));
        in_valid = 1'b0;
        tick(); tick();
        send(row(8'd3, 8'd30, 8'd255, 8'd0));
        t = cyc;
        send(row(8'd4, 8'd40, 8'd255, 8'd0));
        in_valid = 1'b0;
        wait_out("t2", t, {12'd0, 12'h3FC, 12'd100, 12'd10});
        for (int k = 0; k < 4; k++) chk($sformatf("t2_clr_cnt_%0d", k), 64'(n_clr[k] - base[k]), 64'd1);

        // T3: consumer stalls 10 cycles; junk rows offered meanwhile are ignored
        tick();
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) send(row(8'd4, 8'd3, 8'd2, 8'd1));
        t = cyc;
        send(row(8'd4, 8'd3, 8'd2, 8'd1));
        in_valid = 1'b0;
        wait_out("t3a", t, {12'd4, 12'd8, 12'd12, 12'd16});
        for (int r = 0; r < 10; r++) begin
            tick();
            in_valid = 1'b1; in_data = row(8'd99, 8'd99, 8'd99, 8'd99);
            @(negedge clk);
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_ready", 64'(in_ready), 64'd0);
            chk("t3_hold_data", 64'(out_data), 64'({12'd4, 12'd8, 12'd12, 12'd16}));
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) send(row(8'd100, 8'd50, 8'd25, 8'd200));
        t = cyc;
        send(row(8'd100, 8'd50, 8'd25, 8'd200));
        in_valid = 1'b0;
        wait_out("t3b", t, {12'd800, 12'd100, 12'd200, 12'd400});

        // T4: reset after row 2 discards the partial block
        tick();
        send(row(8'd7, 8'd7, 8'd7, 8'd7));
        send(row(8'd7, 8'd7, 8'd7, 8'd7));
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_out_data_cleared", 64'(out_data), 64'd0);
        for (int r = 0; r < 12; r++) begin
            tick();
            @(negedge clk);
            chk("t4_no_out_valid", 64'(out_valid), 64'd0);
        end
        tick();
        for (int r = 0; r < 3; r++) send(row(8'd5, 8'd5, 8'd5, 8'd5));
        t = cyc;
        send(row(8'd5, 8'd5, 8'd5, 8'd5));
        in_valid = 1'b0;
        wait_out("t4", t, {12'd20, 12'd20, 12'd20, 12'd20});

        // T5: blockLen=16 with zBits 12 and 8
        tick();
        for (int r = 0; r < 16; r++) begin
            v_valid = 1'b1; v_data = 32'hFFFF_FFFF; t = cyc;
            @(negedge clk);
            chk("v16_ready", 64'(v16_ready), 64'd1);
            chk("v8_ready", 64'(v8_ready), 64'd1);
            tick();
        end
        v_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (v16_ovalid) seen = 1'b1;
        end
        chk("v16_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("v16_latency", 64'(cyc - t), 64'd6);
            chk("v16_data", 64'(v16_odata), 64'({12'hFF0, 12'hFF0, 12'hFF0, 12'hFF0}));
            chk("v8_valid", 64'(v8_ovalid), 64'd1);
            chk("v8_data", 64'(v8_odata), 64'h0000_0000_F0F0_F0F0);
        end

        // T6: blockLen=1, single row
        tick();
        w1_valid = 1'b1; w1_data = row(8'd1, 8'd2, 8'd3, 8'd4); t = cyc;
        tick();
        w1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("d1_clear_at_%0d", k), 64'(d1_cvec), 64'(4'b0001 << k));
            chk($sformatf("d1_a_%0d", k), 64'(d1_avec[8*k +: 8]), 64'(k + 1));
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (d1_ovalid) seen = 1'b1;
        end
        chk("d1_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("d1_latency", 64'(cyc - t), 64'd6);
            chk("d1_data", 64'(d1_odata), 64'({12'd4, 12'd3, 12'd2, 12'd1}));
        end

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
